// File: rtl/qs_scalar_mac_pkg.sv
// Shared constants and FSM state type for the qs scalar multiplier.
// Optional accumulate input is enabled by defining QS_SCALAR_MAC_ACC_EN.
package qs_scalar_mac_pkg;
    localparam int QS_W        = 59;   // ROM word width
    localparam int QS_NWORDS   = 4;    // words forming Q
    localparam int QS_SELW     = 6;    // ROM select width
    localparam int QS_SEL_BASE = 0;    // ROM index of Q word 0 (LSW)

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } qs_state_t;
endpackage

// File: rtl/qs_scalar_mac_if.sv
// Result stream of the qs scalar multiplier: LSW-first words with a
// valid/ready handshake and a last-word marker.
interface qs_scalar_mac_if
    import qs_scalar_mac_pkg::*;
#(
    parameter int W = QS_W
);
    logic [W-1:0] out_word;
    logic         out_valid;
    logic         out_last;
    logic         out_ready;

    modport master (output out_word, output out_valid, output out_last, input out_ready);
    modport slave  (input out_word, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/qs_scalar_mac_muladd.sv
// Combinational W x W + W + W -> 2W multiply-add, intended for a DSP slice.
// Must stay unpipelined: the parent's one-word-per-cycle timing relies on it.
module qs_scalar_mac_muladd
    import qs_scalar_mac_pkg::*;
#(
    parameter int W = QS_W
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [W-1:0]   c,
    input  logic [W-1:0]   d,
    output logic [2*W-1:0] p
);
    // (2^W-1)^2 + 2*(2^W-1) = 2^2W-1, so the 2W-bit result never wraps.
    assign p = ({{W{1'b0}}, a} * {{W{1'b0}}, b}) + {{W{1'b0}}, c} + {{W{1'b0}}, d};
endmodule

// File: rtl/qs_scalar_mac.sv
// Multi-word scalar multiplier R = scalar * Q, Q read word by word from the
// registered qs ROM. Streams R LSW-first as NWORDS+1 words.
// Define QS_SCALAR_MAC_ACC_EN to add the acc_word/acc_rd accumulate port.
module qs_scalar_mac
    import qs_scalar_mac_pkg::*;
#(
    parameter int W        = QS_W,
    parameter int NWORDS   = QS_NWORDS,
    parameter int SELW     = QS_SELW,
    parameter int SEL_BASE = QS_SEL_BASE
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [W-1:0]    scalar,
    output logic [SELW-1:0] sel,
    input  logic [W-1:0]    qs_word,
`ifdef QS_SCALAR_MAC_ACC_EN
    input  logic [W-1:0]    acc_word,
    output logic            acc_rd,
`endif
    output logic            busy,
    qs_scalar_mac_if.master out_if
);
    localparam int IDXW = $clog2(NWORDS + 1);

    qs_state_t          state_reg;
    qs_state_t          state_next;
    logic [IDXW-1:0]    idx_reg;
    logic [W-1:0]       carry_reg;
    logic [W-1:0]       scalar_reg;
    logic [W-1:0]       out_word_reg;
    logic               out_valid_reg;
    logic               out_last_reg;

    logic               slot_free;
    logic               fire;
    logic               flush_go;
    logic               start_ok;
    logic [W-1:0]       acc_term;
    logic [2*W-1:0]     prod;

`ifdef QS_SCALAR_MAC_ACC_EN
    assign acc_term = acc_word;
    assign acc_rd   = fire;
`else
    assign acc_term = '0;
`endif

    qs_scalar_mac_muladd #(.W(W)) u_muladd (
        .a (scalar_reg),
        .b (qs_word),
        .c (carry_reg),
        .d (acc_term),
        .p (prod)
    );

    assign out_if.out_word  = out_word_reg;
    assign out_if.out_valid = out_valid_reg;
    assign out_if.out_last  = out_last_reg;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: one PRIME cycle covers the ROM read latency of word 0.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start) state_next = ST_PRIME;
            ST_PRIME: state_next = ST_RUN;
            ST_RUN:   if (fire && (idx_reg == IDXW'(NWORDS - 1))) state_next = ST_FLUSH;
            ST_FLUSH: if (slot_free) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Outputs and strobes; sel looks one word ahead on fire so a stall re-reads the same word.
    always_comb begin
        busy      = (state_reg != ST_IDLE);
        slot_free = !out_valid_reg || out_if.out_ready;
        fire      = (state_reg == ST_RUN) && slot_free;
        flush_go  = (state_reg == ST_FLUSH) && slot_free;
        start_ok  = (state_reg == ST_IDLE) && start;
        if (state_reg == ST_IDLE) begin
            sel = SELW'(SEL_BASE);
        end else begin
            sel = SELW'(SEL_BASE) + SELW'(idx_reg) + SELW'(fire);
        end
    end

    // Datapath: scalar capture, carry chain, word index and the output holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg       <= '0;
            carry_reg     <= '0;
            scalar_reg    <= '0;
            out_word_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
        end else begin
            if (start_ok) begin
                scalar_reg <= scalar;
                carry_reg  <= '0;
                idx_reg    <= '0;
            end
            if (fire) begin
                out_word_reg  <= prod[W-1:0];
                carry_reg     <= prod[2*W-1:W];
                out_valid_reg <= 1'b1;
                out_last_reg  <= 1'b0;
                idx_reg       <= idx_reg + IDXW'(1);
            end else if (flush_go) begin
                out_word_reg  <= carry_reg;
                out_valid_reg <= 1'b1;
                out_last_reg  <= 1'b1;
            end else if (out_valid_reg && out_if.out_ready) begin
                out_valid_reg <= 1'b0;
                out_last_reg  <= 1'b0;
            end
        end
    end
endmodule
